// File: rtl/aes_add_round_key_stage.sv
// AES-128 AddRoundKey stage with an on-chip key schedule that expands one round key per cycle.
// Latency 1 cycle. Input stalls until the schedule is ready and output space exists.
// Define AES_ARK_SKID_EN for a 2-entry skid buffer with a registered in_ready_o.
module aes_add_round_key_stage #(
  parameter int NR = 10,
  parameter int RW = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          key_load_i,
  input  logic [0:127]  key_i,
  output logic          key_ready_o,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [0:127]  in_state_i,
  input  logic [RW-1:0] in_round_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [0:127]  out_state_o
);

  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_e;

  localparam logic [3:0]    NR_C = 4'(NR);
  localparam logic [RW-1:0] NR_R = RW'(NR);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // x^254 as the product x^2 * x^4 * ... * x^128; zero maps to zero for free.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = gf_mul(a, a);
    inv = sq;
    for (int i = 0; i < 6; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] n);
    case (n)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [0:127] expand(input logic [0:127] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, rot, t, n0, n1, n2, n3;
    w0  = k[0:31];
    w1  = k[32:63];
    w2  = k[64:95];
    w3  = k[96:127];
    rot = {w3[23:0], w3[31:24]};
    t   = {sbox(rot[31:24]) ^ rc, sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    n0  = w0 ^ t;
    n1  = w1 ^ n0;
    n2  = w2 ^ n1;
    n3  = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [0:127] rk_q [0:NR];
  logic         rk_load, rk_we;
  logic [3:0]   prev_idx;
  logic [0:127] rk_prev, rk_next, rk_sel, result;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rk_load = 1'b0;
    rk_we   = 1'b0;
    case (state_q)
      IDLE, READY: begin
        if (key_load_i) begin
          state_d = EXPAND;
          cnt_d   = 4'd1;
          rk_load = 1'b1;
        end
      end
      EXPAND: begin
        rk_we = 1'b1;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == NR_C) state_d = READY;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign prev_idx = cnt_q - 4'd1;
  assign rk_prev  = (prev_idx <= NR_C) ? rk_q[prev_idx] : '0;
  assign rk_next  = expand(rk_prev, rcon(cnt_q));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
    end else if (rk_load) begin
      rk_q[0] <= key_i;
    end else if (rk_we) begin
      rk_q[cnt_q] <= rk_next;
    end
  end

  // Out-of-range round indices use an all-zero key, passing the state through.
  assign rk_sel      = (in_round_i <= NR_R) ? rk_q[in_round_i] : '0;
  assign result      = in_state_i ^ rk_sel;
  assign key_ready_o = (state_q == READY);

`ifdef AES_ARK_SKID_EN
  logic [1:0]   sk_cnt_q, sk_cnt_d;
  logic [0:127] ent0_q, ent0_d, ent1_q, ent1_d;
  logic         in_rdy_q, in_rdy_d;
  logic         push, pop;

  assign push = in_valid_i && in_rdy_q;
  assign pop  = (sk_cnt_q != 2'd0) && out_ready_i;

  // ent0 is always the head, so the output comes straight from a register.
  always_comb begin
    sk_cnt_d = sk_cnt_q;
    ent0_d   = ent0_q;
    ent1_d   = ent1_q;
    case ({push, pop})
      2'b10: begin
        if (sk_cnt_q == 2'd0) ent0_d = result;
        else                  ent1_d = result;
        sk_cnt_d = sk_cnt_q + 2'd1;
      end
      2'b01: begin
        ent0_d   = ent1_q;
        sk_cnt_d = sk_cnt_q - 2'd1;
      end
      2'b11: begin
        if (sk_cnt_q == 2'd1) begin
          ent0_d = result;
        end else begin
          ent0_d = ent1_q;
          ent1_d = result;
        end
      end
      default: ;
    endcase
    in_rdy_d = (state_d == READY) && (sk_cnt_d != 2'd2);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sk_cnt_q <= 2'd0;
      ent0_q   <= '0;
      ent1_q   <= '0;
      in_rdy_q <= 1'b0;
    end else begin
      sk_cnt_q <= sk_cnt_d;
      ent0_q   <= ent0_d;
      ent1_q   <= ent1_d;
      in_rdy_q <= in_rdy_d;
    end
  end

  assign in_ready_o  = in_rdy_q;
  assign out_valid_o = (sk_cnt_q != 2'd0);
  assign out_state_o = ent0_q;
`else
  logic         out_valid_q, out_valid_d;
  logic [0:127] out_state_q, out_state_d;
  logic         accept;

  assign in_ready_o = (state_q == READY) && (!out_valid_q || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    out_valid_d = out_valid_q;
    out_state_d = out_state_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_state_d = result;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_state_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_state_q <= out_state_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_state_o = out_state_q;
`endif

endmodule

// File: tb/tb_aes_add_round_key_stage.sv
// Scoreboard bench for aes_add_round_key_stage with a FIPS-197-style reference key schedule.
module tb_aes_add_round_key_stage;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_load;
  logic [0:127] key_in;
  logic         key_ready;
  logic         in_valid;
  logic         in_ready;
  logic [0:127] in_state;
  logic [3:0]   in_round;
  logic         out_valid;
  logic         out_ready;
  logic [0:127] out_state;

  aes_add_round_key_stage #(.NR(10), .RW(4)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .key_load_i  (key_load),
    .key_i       (key_in),
    .key_ready_o (key_ready),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_state_i  (in_state),
    .in_round_i  (in_round),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_state_o (out_state)
  );

  always #5 clk = ~clk;

  localparam logic [0:127] K0   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [0:127] RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [0:127] DS   = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [0:127] DO   = 128'ha49c7ff2689f352b6b5bea43026a5049;

  int checks = 0;
  int failures = 0;
  int stall_cnt = 0;
  logic [0:127] sb_q[$];
  logic [7:0]   sb_tab [0:255];
  logic [0:127] mrk [0:10];
  logic         rand_run;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    int r, x;
    r = 0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (((b >> i) & 1) != 0) r = r ^ x;
      x = x << 1;
      if ((x & 256) != 0) x = x ^ 'h11b;
    end
    return r[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, c, s;
    c = 8'h63;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (m_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb_tab[a] = s;
    end
  endtask

  task automatic build_model(input logic [0:127] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb_tab[t[31:24]], sb_tab[t[23:16]], sb_tab[t[15:8]], sb_tab[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = m_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) mrk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [0:127] exp_of(input logic [0:127] st, input logic [3:0] rnd);
    return (rnd <= 4'd10) ? (st ^ mrk[rnd]) : st;
  endfunction

  function automatic logic [0:127] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [0:127] st, input logic [3:0] rnd, input logic [0:127] exp);
    int n;
    bit acc;
    n = 0;
    acc = 0;
    in_valid = 1'b1;
    in_state = st;
    in_round = rnd;
    while (!acc && n < 200) begin
      #4;
      if (in_ready) begin
        sb_q.push_back(exp);
        acc = 1;
      end
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    if (acc) stall_cnt += n - 1;
    else chk("send_timeout", 0, 1);
  endtask

  task automatic send_rand();
    logic [0:127] st;
    logic [3:0]   r;
    st = rnd128();
    r  = 4'($urandom_range(0, 15));
    send(st, r, exp_of(st, r));
  endtask

  // Pulses key_load at a negedge; optional second pulse with alt key at cycle glitch.
  task automatic load_key(input logic [0:127] key, input logic [0:127] alt, input int glitch,
                          output int cyc, output bit rdy_seen);
    key_load = 1'b1;
    key_in   = key;
    rdy_seen = 0;
    @(negedge clk);
    key_load = 1'b0;
    cyc = 1;
    while (!key_ready && cyc < 40) begin
      if (in_ready) rdy_seen = 1;
      if (cyc == glitch) begin
        key_load = 1'b1;
        key_in   = alt;
      end else begin
        key_load = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    key_load = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(sb_q.size()), 0);
  endtask

  logic         prev_stall;
  logic [0:127] prev_state;
  initial begin
    prev_stall = 1'b0;
    prev_state = '0;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n !== 1'b1) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", 128'(out_valid), 1);
          chk("hold_state", out_state, prev_state);
        end
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) chk("unexpected_output", out_state, 0);
          else chk("out_state", out_state, sb_q.pop_front());
        end
        prev_stall = out_valid && !out_ready;
        prev_state = out_state;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bit rs;
    logic [0:127] k2, k3, k4, ones, st;
    rst_n = 1'b0; key_load = 1'b0; key_in = '0; in_valid = 1'b0;
    in_state = '0; in_round = '0; out_ready = 1'b1; rand_run = 1'b0;
    ones = '1;
    build_sbox();
    repeat (3) @(negedge clk);
    chk("rst_key_ready", 128'(key_ready), 0);
    chk("rst_out_valid", 128'(out_valid), 0);
    chk("rst_out_state", out_state, 0);
    chk("rst_in_ready", 128'(in_ready), 0);
    rst_n = 1'b1;
    @(negedge clk);

    load_key(K0, '0, 0, cyc, rs);
    chk("load_latency", 128'(cyc), 11);
    chk("in_ready_during_expand", 128'(rs), 0);
    build_model(K0);

    send('0, 4'd0, K0);
    #4;
    chk("latency_valid", 128'(out_valid), 1);
    chk("latency_state", out_state, K0);
    @(negedge clk);
    send('0, 4'd1, RK1);
    send('0, 4'd10, RK10);
    send(DS, 4'd1, DO);
    send(ones, 4'd11, ones);
    st = rnd128();
    send(st, 4'd15, st);
    stall_cnt = 0;
    for (int i = 0; i < 20; i++) send_rand();
    chk("burst_stalls", 128'(stall_cnt), 0);
    drain();

    fork
      begin
        out_ready = 1'b0;
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 8; i++) send_rand();
      end
    join
    drain();

    rand_run = 1'b1;
    fork
      begin
        while (rand_run) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(negedge clk);
        end
      end
      begin
        for (int i = 0; i < 60; i++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          send_rand();
        end
        rand_run = 1'b0;
      end
    join
    out_ready = 1'b1;
    drain();

    k2 = rnd128();
    k3 = rnd128();
    load_key(k2, k3, 3, cyc, rs);
    chk("load_latency_ignored", 128'(cyc), 11);
    build_model(k2);
    send('0, 4'd0, k2);
    send('0, 4'd10, mrk[10]);
    for (int i = 0; i < 5; i++) send_rand();
    drain();

    out_ready = 1'b0;
    send_rand();
    k4 = rnd128();
    key_load = 1'b1;
    key_in   = k4;
    @(negedge clk);
    key_load = 1'b0;
    rs = 0;
    for (int i = 0; i < 10; i++) begin
      if (in_ready || key_ready) rs = 1;
      @(negedge clk);
    end
    chk("reload_in_ready_low", 128'(rs), 0);
    chk("pending_valid", 128'(out_valid), 1);
    chk("pending_state", out_state, sb_q[0]);
    out_ready = 1'b1;
    cyc = 0;
    while (!key_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("reload_ready", 128'(key_ready), 1);
    build_model(k4);
    send('0, 4'd0, k4);
    for (int i = 0; i < 5; i++) send_rand();
    drain();

    out_ready = 1'b0;
    send_rand();
    key_load = 1'b1;
    key_in   = rnd128();
    @(negedge clk);
    key_load = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    chk("midrst_key_ready", 128'(key_ready), 0);
    chk("midrst_out_valid", 128'(out_valid), 0);
    chk("midrst_out_state", out_state, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    load_key(K0, '0, 0, cyc, rs);
    chk("reload_after_rst", 128'(cyc), 11);
    build_model(K0);
    send('0, 4'd10, RK10);
    send('0, 4'd0, K0);
    for (int i = 0; i < 5; i++) send_rand();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
